rggen_bit_field_access_initiator: RTL and testbench

RGGEN_BIT_FIELD_ACCESS_INITIATOR -- requirements
Module: rggen_bit_field_access_initiator

---
 rtl/rggen_bit_field_access_initiator_if.sv | 33 +++
 rtl/rggen_bit_field_access_initiator.sv | 144 ++++++++++++++
 tb/tb_rggen_bit_field_access_initiator.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_bit_field_access_initiator_if.sv
// rggen_bit_field_if
//   Bit-field access bus shared between an access initiator (master) and a
//   bit-field register (slave).
//   valid      : one-cycle access strobe
//   read_mask  : bits being read during the access
//   write_mask : bits to be updated during the access
//   write_data : new value for the bits selected by write_mask
//   read_data  : current field value returned by the slave
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;

  modport master (
    output valid,
    output read_mask,
    output write_mask,
    output write_data,
    input  read_data
  );

  modport slave (
    input  valid,
    input  read_mask,
    input  write_mask,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/rggen_bit_field_access_initiator.sv
// rggen_bit_field_access_initiator
//   Turns a valid/ready command (read, write, set-bits, clear-bits) into a
//   single-cycle access on a bit-field bus and returns the pre-access field
//   value through a valid/ready response channel.
//   Ports:
//     i_clk, i_rst                 : clock, asynchronous active-high reset
//     i_cmd_valid / o_cmd_ready    : command handshake
//     i_cmd_op                     : 00 read, 01 write, 10 set-bits, 11 clear-bits
//     i_cmd_data, i_cmd_mask       : write data and bit-enable mask
//     o_rsp_valid / i_rsp_ready    : response handshake
//     o_rsp_data                   : field value seen during the access
//     o_busy                       : high whenever a command is in flight
//     bit_field_if                 : master side of the bit-field bus
module rggen_bit_field_access_initiator #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic [WIDTH-1:0] i_cmd_mask,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_busy,
  rggen_bit_field_if.master bit_field_if
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] rsp_data_reg;

  logic             cmd_ready;
  logic             rsp_valid;
  logic             busy;
  logic             bf_valid;
  logic [WIDTH-1:0] bf_read_mask;
  logic [WIDTH-1:0] bf_write_mask;
  logic [WIDTH-1:0] bf_write_data;

  // Command fields are only captured on an IDLE handshake, so changes on
  // i_cmd_* while a command is in flight have no effect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      op_reg       <= OP_READ;
      data_reg     <= '0;
      mask_reg     <= '0;
      rsp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && i_cmd_valid) begin
        op_reg   <= i_cmd_op;
        data_reg <= i_cmd_data;
        mask_reg <= i_cmd_mask;
      end
      // The slave updates the field at this same edge, so read_data here is
      // still the pre-write value.
      if (state_reg == ACCESS) begin
        rsp_data_reg <= bit_field_if.read_data;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    busy          = 1'b1;
    bf_valid      = 1'b0;
    bf_read_mask  = '0;
    bf_write_mask = '0;
    bf_write_data = '0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (i_cmd_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        bf_valid     = 1'b1;
        bf_read_mask = '1;
        case (op_reg)
          OP_READ: begin
            bf_write_mask = '0;
          end
          OP_WRITE: begin
            bf_write_mask = mask_reg;
            bf_write_data = data_reg;
          end
          OP_SET: begin
            bf_write_mask = mask_reg;
            bf_write_data = '1;
          end
          OP_CLEAR: begin
            bf_write_mask = mask_reg;
            bf_write_data = '0;
          end
          default: begin
            bf_write_mask = '0;
          end
        endcase
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_cmd_ready             = cmd_ready;
  assign o_rsp_valid             = rsp_valid;
  assign o_rsp_data              = rsp_data_reg;
  assign o_busy                  = busy;
  assign bit_field_if.valid      = bf_valid;
  assign bit_field_if.read_mask  = bf_read_mask;
  assign bit_field_if.write_mask = bf_write_mask;
  assign bit_field_if.write_data = bf_write_data;

endmodule

// File: tb/tb_rggen_bit_field_access_initiator.sv
// Testbench for rggen_bit_field_access_initiator (WIDTH = 8).
module tb_rggen_bit_field_access_initiator;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] cmd_mask;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         busy;

  always #5 clk = ~clk;

  rggen_bit_field_if #(.WIDTH(W)) bf ();

  rggen_bit_field_access_initiator #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_data   (cmd_data),
    .i_cmd_mask   (cmd_mask),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy),
    .bit_field_if (bf)
  );

  // Bit-field register acting as the slave on the bus.
  logic [W-1:0] field_q = '0;
  logic         preload_en = 1'b0;
  logic [W-1:0] preload_val = '0;
  assign bf.read_data = field_q;

  always @(posedge clk) begin
    if (preload_en)
      field_q <= preload_val;
    else if (bf.valid)
      field_q <= (field_q & ~bf.write_mask) | (bf.write_data & bf.write_mask);
  end

  // Bus / handshake monitor.
  int           cyc = 0;
  int           pulse_cnt = 0;
  int           rsp_hs_cnt = 0;
  int           drive_viol = 0;
  logic [W-1:0] last_rmask = '0;
  logic [W-1:0] last_wmask = '0;
  logic [W-1:0] last_wdata = '0;
  int           accept_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bf.valid) begin
      pulse_cnt  <= pulse_cnt + 1;
      last_rmask <= bf.read_mask;
      last_wmask <= bf.write_mask;
      last_wdata <= bf.write_data;
    end else if (bf.read_mask != '0 || bf.write_mask != '0 || bf.write_data != '0) begin
      drive_viol <= drive_viol + 1;
    end
    if (rsp_valid && rsp_ready) rsp_hs_cnt <= rsp_hs_cnt + 1;
    if (cmd_valid && cmd_ready) accept_q.push_back(cyc);
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [W-1:0] v);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_val = v;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  // One complete command with the response consumed as soon as offered.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [W-1:0] mask, output logic [W-1:0] rsp);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_mask  = mask;
    rsp_ready = 1'b1;
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = 8'($urandom);
    cmd_mask  = 8'($urandom);
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rsp_latency", 32'(t), 32'd1);
    rsp = rsp_data;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("back_to_idle", {30'd0, cmd_ready, busy}, {30'd0, 1'b1, 1'b0});
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] mask;
    bit           do_preset;
    logic [W-1:0] preset;
    logic [W-1:0] exp_rsp;
    logic [W-1:0] exp_field;
    logic [W-1:0] exp_wmask;
    logic [W-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [W-1:0] model_next(input logic [1:0] op, input logic [W-1:0] v,
                                              input logic [W-1:0] d, input logic [W-1:0] m);
    case (op)
      2'b01:   return (v & ~m) | (d & m);
      2'b10:   return v | m;
      2'b11:   return v & ~m;
      default: return v;
    endcase
  endfunction

  initial begin
    logic [W-1:0] rsp;
    logic [W-1:0] model_val;
    logic [W-1:0] held;
    int p0;
    int h0;
    int t;

    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    cmd_mask  = '0;
    rsp_ready = 1'b0;

    // Reset state, checked before the first clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_bf_valid", 32'(bf.valid), 32'd0);
    check("rst_bf_masks", {8'd0, bf.read_mask, bf.write_mask, bf.write_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    vecs[0] = '{2'b00, 8'h00, 8'hFF, 1'b1, 8'h2A, 8'h2A, 8'h2A, 8'h00, 8'h00};
    vecs[1] = '{2'b01, 8'hA5, 8'hF0, 1'b1, 8'h0F, 8'h0F, 8'hAF, 8'hF0, 8'hA5};
    vecs[2] = '{2'b10, 8'h33, 8'h81, 1'b1, 8'h00, 8'h00, 8'h81, 8'h81, 8'hFF};
    vecs[3] = '{2'b11, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h81, 8'h80, 8'h01, 8'h00};
    vecs[4] = '{2'b01, 8'h5A, 8'h00, 1'b1, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h5A};
    vecs[5] = '{2'b00, 8'hFF, 8'hFF, 1'b1, 8'hC3, 8'hC3, 8'hC3, 8'h00, 8'h00};

    foreach (vecs[i]) begin
      if (vecs[i].do_preset) preload(vecs[i].preset);
      p0 = pulse_cnt;
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].mask, rsp);
      $display("vec %0d op=%0d data=%02h mask=%02h rsp=%02h field=%02h",
               i, vecs[i].op, vecs[i].data, vecs[i].mask, rsp, field_q);
      check($sformatf("vec%0d_rsp", i), 32'(rsp), 32'(vecs[i].exp_rsp));
      check($sformatf("vec%0d_field", i), 32'(field_q), 32'(vecs[i].exp_field));
      check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - p0), 32'd1);
      check($sformatf("vec%0d_rmask", i), 32'(last_rmask), 32'hFF);
      check($sformatf("vec%0d_wmask", i), 32'(last_wmask), 32'(vecs[i].exp_wmask));
      if (vecs[i].op != 2'b00)
        check($sformatf("vec%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].exp_wdata));
    end

    // Randomized commands against the op-level model.
    model_val = 8'($urandom);
    preload(model_val);
    for (int i = 0; i < 30; i++) begin
      logic [1:0]   op;
      logic [W-1:0] d;
      logic [W-1:0] m;
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      m  = 8'($urandom);
      p0 = pulse_cnt;
      run_cmd(op, d, m, rsp);
      $display("rnd %0d op=%0d data=%02h mask=%02h rsp=%02h field=%02h", i, op, d, m, rsp, field_q);
      check($sformatf("rnd%0d_rsp", i), 32'(rsp), 32'(model_val));
      model_val = model_next(op, model_val, d, m);
      check($sformatf("rnd%0d_field", i), 32'(field_q), 32'(model_val));
      check($sformatf("rnd%0d_pulses", i), 32'(pulse_cnt - p0), 32'd1);
    end

    // Backpressure: response held for 5 cycles.
    preload(8'h9C);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    held = rsp_data;
    check("bp_rsp_data", 32'(held), 32'h9C);
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_op   = 2'($urandom);
      cmd_data = 8'($urandom);
      cmd_mask = 8'($urandom);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", 32'(rsp_data), 32'(held));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    check("bp_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    $display("backpressure rsp=%02h held 5 cycles", held);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("bp_release_idle", {30'd0, cmd_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});

    // Throughput: four back-to-back reads.
    preload(8'h77);
    @(negedge clk);
    accept_q.delete();
    p0 = pulse_cnt;
    h0 = rsp_hs_cnt;
    cmd_op    = 2'b00;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    t = 0;
    while (accept_q.size() < 4 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    check("tp_accepts", 32'(accept_q.size()), 32'd4);
    for (int i = 1; i < accept_q.size(); i++)
      check($sformatf("tp_gap%0d", i), 32'(accept_q[i] - accept_q[i-1]), 32'd3);
    check("tp_pulses", 32'(pulse_cnt - p0), 32'd4);
    check("tp_responses", 32'(rsp_hs_cnt - h0), 32'd4);
    $display("throughput accepts=%0d pulses=%0d", accept_q.size(), pulse_cnt - p0);

    // Reset during ACCESS: the write must never reach the field.
    preload(8'h55);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 8'h00;
    cmd_mask  = 8'hFF;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("ra_in_access", 32'(bf.valid), 32'd1);
    p0 = pulse_cnt;
    h0 = rsp_hs_cnt;
    rst = 1'b1;
    #1;
    check("ra_outputs", {27'd0, cmd_ready, rsp_valid, busy, bf.valid, 1'b0}, {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("ra_bus", {8'd0, bf.read_mask, bf.write_mask, bf.write_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ra_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("ra_no_rsp", 32'(rsp_hs_cnt - h0), 32'd0);
    check("ra_field", 32'(field_q), 32'h55);
    check("ra_idle", {30'd0, cmd_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
    rsp_ready = 1'b0;
    run_cmd(2'b00, 8'h00, 8'h00, rsp);
    check("ra_next_cmd", 32'(rsp), 32'h55);
    $display("reset in ACCESS then read rsp=%02h", rsp);

    // Reset during RESP: the response is dropped.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_mask  = 8'h0A;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rr_in_resp", 32'(rsp_valid), 32'd1);
    p0 = pulse_cnt;
    h0 = rsp_hs_cnt;
    rst = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("rr_outputs", {28'd0, cmd_ready, rsp_valid, busy, bf.valid}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("rr_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("rr_no_rsp", 32'(rsp_hs_cnt - h0), 32'd0);
    check("rr_field", 32'(field_q), 32'h5F);
    rsp_ready = 1'b0;
    run_cmd(2'b11, 8'h00, 8'h0F, rsp);
    check("rr_next_rsp", 32'(rsp), 32'h5F);
    check("rr_next_field", 32'(field_q), 32'h50);
    $display("reset in RESP then clear rsp=%02h field=%02h", rsp, field_q);

    check("idle_bus_quiet", 32'(drive_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
